// File: rtl/lc3_rf_pkg.sv
// LC-3 register file shared types and defaults.
// Used by decode, writeback and the interrupt controller.
package lc3_rf_pkg;

  localparam int LC3_DATA_W   = 16;
  localparam int LC3_NUM_REGS = 8;

  typedef enum logic [1:0] {
    IDLE,
    QUIESCE,
    DUMP,
    LOAD
  } rf_state_e;

endpackage

// File: rtl/lc3_scoreboard.sv
// Per-register busy scoreboard.
// Issue sets and writeback clears; set wins on the same register.
module lc3_scoreboard
  import lc3_rf_pkg::*;
#(
  parameter  int NUM_REGS = LC3_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              empty
);

  logic [NUM_REGS-1:0] busy;

  // Out-of-range indices never match, so they are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && set_idx == ADDR_W'(i))
          busy[i] <= 1'b1;
        else if (clr_en && clr_idx == ADDR_W'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  function automatic logic lookup(
    input logic [ADDR_W-1:0] a
  );
    lookup = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i))
        lookup = busy[i];
  endfunction

  assign rd1_busy = lookup(rd1_addr);
  assign rd2_busy = lookup(rd2_addr);
  assign empty    = ~|busy;

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with busy scoreboard and
// serial context dump/restore engine.
module lc3_regfile_sb
  import lc3_rf_pkg::*;
#(
  parameter  int DATA_W   = LC3_DATA_W,
  parameter  int NUM_REGS = LC3_NUM_REGS,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_busy,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_busy,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dr,
  output logic              iss_stall,
  input  logic              dump_start,
  input  logic              load_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              eng_done,
  output logic              wr_drop
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  rf_state_e         state;
  logic [ADDR_W-1:0] idx;
  logic              wr_acc;
  logic              load_beat;
  logic              last;
  logic              sb_empty;

  assign wr_acc    = wr_en && (state != LOAD);
  assign load_beat = (state == LOAD) && load_valid;
  assign wr_drop   = wr_en && (state == LOAD);
  assign last      = (idx == ADDR_W'(NUM_REGS - 1));

  // Register value, optionally with this cycle's write
  // forwarded; out-of-range addresses read as zero.
  function automatic logic [DATA_W-1:0] reg_val(
    input logic [ADDR_W-1:0] a,
    input logic              fwd
  );
    reg_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i))
        reg_val = (fwd && wr_acc && wr_addr == a) ?
                  wr_data : regs[i];
  endfunction

  assign rd1_data = reg_val(rd1_addr, BYPASS != 0);
  assign rd2_data = reg_val(rd2_addr, BYPASS != 0);

  lc3_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_en && !iss_stall),
    .set_idx  (iss_dr),
    .clr_en   (wr_acc || load_beat),
    .clr_idx  (load_beat ? idx : wr_addr),
    .rd1_addr (rd1_addr),
    .rd2_addr (rd2_addr),
    .rd1_busy (rd1_busy),
    .rd2_busy (rd2_busy),
    .empty    (sb_empty)
  );

  // Storage: restore beats own the file during LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_beat && idx == ADDR_W'(i))
          regs[i] <= load_data;
        else if (wr_acc && wr_addr == ADDR_W'(i))
          regs[i] <= wr_data;
      end
    end
  end

  // Context engine with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      load_ready <= 1'b0;
      eng_done   <= 1'b0;
      iss_stall  <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (dump_start) begin
            state     <= QUIESCE;
            iss_stall <= 1'b1;
          end else if (load_start) begin
            state      <= LOAD;
            iss_stall  <= 1'b1;
            load_ready <= 1'b1;
          end
        end
        QUIESCE: begin
          if (sb_empty) begin
            state      <= DUMP;
            dump_valid <= 1'b1;
            dump_data  <= reg_val('0, 1'b1);
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (last) begin
              state      <= IDLE;
              dump_valid <= 1'b0;
              eng_done   <= 1'b1;
              iss_stall  <= 1'b0;
            end else begin
              idx       <= idx + 1'b1;
              dump_data <= reg_val(idx + 1'b1, 1'b1);
            end
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (last) begin
              state      <= IDLE;
              load_ready <= 1'b0;
              eng_done   <= 1'b1;
              iss_stall  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
